// File: rtl/lora_pkg.sv
// rtl/lora_pkg.sv - shared constants, command codes and frame-state enum for the LoRa TX path
package lora_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_ACK  = 2'd1;
  localparam logic [1:0] CMD_REQ  = 2'd2;
  localparam logic [1:0] CMD_ERR  = 2'd3;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_SEND = 2'd1,
    F_DONE = 2'd2
  } frame_state_t;

endpackage

// File: rtl/lora_tx_if.sv
// rtl/lora_tx_if.sv - request/serial-line bundle between control logic and lora_tx
interface lora_tx_if;
  logic       tx_start;
  logic [1:0] tx_cmd;
  logic [7:0] tx_data;
  logic       data_tx;
  logic       busy;
  logic       over_tx;

  modport master (
    output tx_start, tx_cmd, tx_data,
    input  data_tx, busy, over_tx
  );

  modport slave (
    input  tx_start, tx_cmd, tx_data,
    output data_tx, busy, over_tx
  );
endinterface

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 LSB-first byte serialiser; a load on the final stop-bit cycle
// chains the next byte with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] byte_in,
  output logic       byte_done,
  output logic       serial
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  logic          active;
  logic [CW-1:0] cnt;
  logic [3:0]    idx;
  logic [7:0]    shreg;
  logic          bit_end;

  assign bit_end   = active && (cnt == CNT_MAX);
  assign byte_done = bit_end && (idx == 4'd9);

  // idx 0 = start bit, 1..8 = data bits, 9 = stop bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      idx    <= 4'd0;
      shreg  <= 8'd0;
      serial <= 1'b1;
    end else if (load) begin
      active <= 1'b1;
      cnt    <= '0;
      idx    <= 4'd0;
      shreg  <= byte_in;
      serial <= 1'b0;
    end else if (bit_end) begin
      cnt <= '0;
      if (idx == 4'd9) begin
        active <= 1'b0;
        idx    <= 4'd0;
        serial <= 1'b1;
      end else begin
        idx <= idx + 4'd1;
        if (idx == 4'd8) begin
          serial <= 1'b1;
        end else begin
          serial <= shreg[0];
          shreg  <= {1'b0, shreg[7:1]};
        end
      end
    end else if (active) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/lora_tx.sv
// rtl/lora_tx.sv - LoRa command-frame transmitter: SOF, cmd, data[, XOR checksum].
// Checksum byte is appended only when LORA_TX_CHKSUM_EN is defined.
module lora_tx
  import lora_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 434,
  parameter logic [7:0] SOF          = SOF_DEFAULT
) (
  input logic        clk,
  input logic        rst,
  lora_tx_if.slave   bus
);

`ifdef LORA_TX_CHKSUM_EN
  localparam logic [1:0] LAST_BYTE = 2'd3;
`else
  localparam logic [1:0] LAST_BYTE = 2'd2;
`endif

  frame_state_t state, state_next;
  logic [1:0]   byte_idx, next_idx;
  logic [1:0]   cmd_q;
  logic [7:0]   data_q;
  logic [7:0]   byte_sel;
  logic         accept, load, byte_done, busy_next, over_next;
`ifdef LORA_TX_CHKSUM_EN
  logic [7:0]   chk_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= F_IDLE;
      byte_idx    <= 2'd0;
      cmd_q       <= 2'd0;
      data_q      <= 8'd0;
`ifdef LORA_TX_CHKSUM_EN
      chk_q       <= 8'd0;
`endif
      bus.busy    <= 1'b0;
      bus.over_tx <= 1'b0;
    end else begin
      state       <= state_next;
      bus.busy    <= busy_next;
      bus.over_tx <= over_next;
      if (load)
        byte_idx <= next_idx;
      else if (state_next == F_DONE)
        byte_idx <= 2'd0;
      if (accept) begin
        cmd_q  <= bus.tx_cmd;
        data_q <= bus.tx_data;
`ifdef LORA_TX_CHKSUM_EN
        chk_q  <= SOF ^ {6'b0, bus.tx_cmd} ^ bus.tx_data;
`endif
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      F_IDLE:  if (bus.tx_start) state_next = F_SEND;
      F_SEND:  if (byte_done && (byte_idx == LAST_BYTE)) state_next = F_DONE;
      F_DONE:  state_next = F_IDLE;
      default: state_next = F_IDLE;
    endcase
  end

  // The first byte is muxed straight from the inputs' capture cycle, so SOF is
  // loaded on the same edge that accepts the request.
  always_comb begin
    accept    = (state == F_IDLE) && bus.tx_start;
    next_idx  = (state == F_SEND) ? byte_idx + 2'd1 : 2'd0;
    load      = accept || ((state == F_SEND) && byte_done && (byte_idx != LAST_BYTE));
    busy_next = (state_next == F_SEND);
    over_next = (state_next == F_DONE);
    case (next_idx)
      2'd0:    byte_sel = SOF;
      2'd1:    byte_sel = {6'b0, cmd_q};
      2'd2:    byte_sel = data_q;
`ifdef LORA_TX_CHKSUM_EN
      2'd3:    byte_sel = chk_q;
`endif
      default: byte_sel = SOF;
    endcase
  end

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .byte_in  (byte_sel),
    .byte_done(byte_done),
    .serial   (bus.data_tx)
  );

endmodule

// File: tb/tb_lora_tx.sv
// tb/tb_lora_tx.sv - randomized self-checking bench for lora_tx against a frame-level waveform model
module tb_lora_tx;
  import lora_pkg::*;

  localparam int CPB = 4;
`ifdef LORA_TX_CHKSUM_EN
  localparam int NB = 4;
`else
  localparam int NB = 3;
`endif
  localparam int T = NB * 10 * CPB;
  localparam int MAXC = 256;
  localparam logic [7:0] SOF_B = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  lora_tx_if bus();

  lora_tx #(.CLKS_PER_BIT(CPB), .SOF(SOF_B)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic obs_tx   [0:MAXC];
  logic obs_busy [0:MAXC];
  logic obs_over [0:MAXC];

  function automatic logic [7:0] exp_byte(int i, logic [1:0] cmd, logic [7:0] d);
    case (i)
      0:       return SOF_B;
      1:       return {6'b0, cmd};
      2:       return d;
      default: return SOF_B ^ {6'b0, cmd} ^ d;
    endcase
  endfunction

  // Line level in cycle c (1 = first cycle after the request was sampled)
  function automatic logic exp_level(int c, logic [1:0] cmd, logic [7:0] d);
    int bp = (c - 1) / CPB;
    int b = bp % 10;
    logic [7:0] v = exp_byte(bp / 10, cmd, d);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return v[b-1];
  endfunction

  function automatic logic [7:0] obs_byte(int i);
    logic [7:0] v;
    for (int b = 0; b < 8; b++)
      v[b] = obs_tx[(i * 10 + 1 + b) * CPB + 1 + CPB / 2];
    return v;
  endfunction

  task automatic start_frame(input logic [1:0] cmd, input logic [7:0] d);
    @(negedge clk);
    bus.tx_cmd   = cmd;
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
  endtask

  task automatic capture(input int ncyc, input int poke_at, input logic [1:0] pcmd,
                         input logic [7:0] pdata, input int rst_at);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1 || c == poke_at + 1) bus.tx_start = 1'b0;
      if (c == rst_at) begin
        rst = 1'b1;
        #1;
      end
      if (c == rst_at + 3) rst = 1'b0;
      obs_tx[c]   = bus.data_tx;
      obs_busy[c] = bus.busy;
      obs_over[c] = bus.over_tx;
      if (c == poke_at) begin
        bus.tx_cmd   = pcmd;
        bus.tx_data  = pdata;
        bus.tx_start = 1'b1;
      end
    end
  endtask

  task automatic test_reset;
    int bad;
    bus.tx_start = 1'b0;
    bus.tx_cmd   = 2'd0;
    bus.tx_data  = 8'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.data_tx, bus.busy, bus.over_tx} !== 3'b100) begin
      errors++;
      $display("FAIL reset_values: got tx/busy/over=%b required 100", {bus.data_tx, bus.busy, bus.over_tx});
    end
    rst = 1'b0;
    bad = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if ({bus.data_tx, bus.busy, bus.over_tx} !== 3'b100) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL idle_50: %0d cycles off idle, required 0", bad);
    end
  endtask

  task automatic test_frame(input logic [1:0] cmd, input logic [7:0] d, input string name);
    int werr, nbusy, nover;
    start_frame(cmd, d);
    capture(T + 2, -10, 2'd0, 8'd0, -10);
    werr = 0; nbusy = 0; nover = 0;
    for (int c = 1; c <= T; c++) begin
      if (obs_tx[c] !== exp_level(c, cmd, d)) werr++;
      if (obs_busy[c] === 1'b1) nbusy++;
      if (obs_over[c] === 1'b1) nover++;
    end
    checks++;
    if (werr !== 0) begin
      errors++;
      $display("FAIL %s wave: %0d cycles differ from model, required 0", name, werr);
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (obs_byte(i) !== exp_byte(i, cmd, d)) begin
        errors++;
        $display("FAIL %s byte%0d: got %h required %h", name, i, obs_byte(i), exp_byte(i, cmd, d));
      end
    end
    checks++;
    if (nbusy !== T || obs_busy[T+1] !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_len: high %0d then %b, required %0d then 0", name, nbusy, obs_busy[T+1], T);
    end
    checks++;
    if (nover !== 0 || obs_over[T+1] !== 1'b1 || obs_over[T+2] !== 1'b0 || obs_tx[T+1] !== 1'b1) begin
      errors++;
      $display("FAIL %s done: early=%0d over=%b%b tx=%b, required 0 10 1", name, nover,
               obs_over[T+1], obs_over[T+2], obs_tx[T+1]);
    end
  endtask

  task automatic test_ignore_start;
    int nover, nbusy;
    start_frame(CMD_REQ, 8'h3C);
    capture(T + 2, 50, CMD_ACK, 8'hFF, -10);
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (obs_byte(i) !== exp_byte(i, CMD_REQ, 8'h3C)) begin
        errors++;
        $display("FAIL ignore byte%0d: got %h required %h", i, obs_byte(i), exp_byte(i, CMD_REQ, 8'h3C));
      end
    end
    nover = 0;
    for (int c = 1; c <= T + 2; c++) if (obs_over[c] === 1'b1) nover++;
    checks++;
    if (nover !== 1 || obs_over[T+1] !== 1'b1) begin
      errors++;
      $display("FAIL ignore over_count: got %0d pulses (at end %b), required 1", nover, obs_over[T+1]);
    end
    capture(20, -10, 2'd0, 8'd0, -10);
    nbusy = 0;
    for (int c = 1; c <= 20; c++) if (obs_busy[c] !== 1'b0) nbusy++;
    checks++;
    if (nbusy !== 0) begin
      errors++;
      $display("FAIL ignore no_requeue: busy seen %0d cycles, required 0", nbusy);
    end
  endtask

  task automatic test_reset_mid_frame;
    int nover, bad;
    start_frame(CMD_ERR, 8'($urandom));
    capture(80, -10, 2'd0, 8'd0, 70);
    checks++;
    if (obs_tx[70] !== 1'b1 || obs_busy[70] !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: tx=%b busy=%b, required 1 0", obs_tx[70], obs_busy[70]);
    end
    nover = 0; bad = 0;
    for (int c = 1; c <= 80; c++) if (obs_over[c] === 1'b1) nover++;
    for (int c = 70; c <= 80; c++) if (obs_tx[c] !== 1'b1 || obs_busy[c] !== 1'b0) bad++;
    checks++;
    if (nover !== 0 || bad !== 0) begin
      errors++;
      $display("FAIL rst_mid abandon: over pulses %0d bad idle %0d, required 0 0", nover, bad);
    end
    test_frame(2'($urandom_range(0, 3)), 8'($urandom), "after_rst");
  endtask

  task automatic test_back_to_back;
    logic [1:0] c1, c2;
    logic [7:0] d1, d2;
    int werr;
    c1 = 2'($urandom_range(0, 3)); d1 = 8'($urandom);
    c2 = 2'($urandom_range(0, 3)); d2 = 8'($urandom);
    start_frame(c1, d1);
    capture(T + 2, T + 2, c2, d2, -10);
    checks++;
    if (obs_over[T+1] !== 1'b1 || obs_over[T+2] !== 1'b0 || obs_byte(2) !== d1) begin
      errors++;
      $display("FAIL b2b first: over=%b%b data=%h, required 10 %h", obs_over[T+1], obs_over[T+2], obs_byte(2), d1);
    end
    capture(T + 2, -10, 2'd0, 8'd0, -10);
    checks++;
    if (obs_tx[1] !== 1'b0 || obs_busy[1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b start: tx=%b busy=%b, required 0 1", obs_tx[1], obs_busy[1]);
    end
    werr = 0;
    for (int c = 1; c <= T; c++) if (obs_tx[c] !== exp_level(c, c2, d2)) werr++;
    checks++;
    if (werr !== 0 || obs_over[T+1] !== 1'b1) begin
      errors++;
      $display("FAIL b2b second: %0d wave diffs over=%b, required 0 1", werr, obs_over[T+1]);
    end
  endtask

  initial begin
    test_reset();
    test_frame(CMD_REQ, 8'h3C, "plan");
    for (int i = 0; i < 4; i++)
      test_frame(2'($urandom_range(0, 3)), 8'($urandom), "random");
    test_frame(CMD_ERR, 8'hFF, "ones");
    test_ignore_start();
    test_reset_mid_frame();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
